// File: rtl/reset_sequencer_if.sv
// Trigger inputs and per-domain reset outputs of reset_sequencer.
// The tb drives through master; the sequencer binds the slave side.
interface reset_sequencer_if #(
    parameter int unsigned NUM_DOMAINS = 3
);
    logic                   fpga_but1;
    logic                   fpgaStart;
    logic                   sw_req;
    logic [NUM_DOMAINS-1:0] reset_n;
    logic                   busy;
    logic [1:0]             cause;

    modport master (
        output fpga_but1,
        output fpgaStart,
        output sw_req,
        input  reset_n,
        input  busy,
        input  cause
    );

    modport slave (
        input  fpga_but1,
        input  fpgaStart,
        input  sw_req,
        output reset_n,
        output busy,
        output cause
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged multi-domain reset sequencer: holds all domains after power-up, button
// or software trigger, then releases them one by one in ascending index order.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES      = 5000000,
    parameter int unsigned DEBOUNCE_CYCLES  = 100000,
    parameter int unsigned NUM_DOMAINS      = 3,
    parameter int unsigned STAGE_GAP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    reset_sequencer_if.slave bus
);
    localparam int unsigned ND  = NUM_DOMAINS;
    localparam int unsigned HCW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned GCW = $clog2(STAGE_GAP_CYCLES + 1);

    localparam logic [1:0] CAUSE_POWER  = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_SW     = 2'b10;

    typedef enum logic [1:0] {
        ST_WAIT_START = 2'd0,
        ST_HOLD       = 2'd1,
        ST_RELEASE    = 2'd2,
        ST_RUN        = 2'd3
    } state_e;

    logic           r_start_s1;
    logic           r_start_s2;
    logic           r_but_s1;
    logic           r_but_s2;
    logic           r_but_deb;
    logic [DCW-1:0] r_deb_cnt;
    logic [DCW-1:0] w_deb_inc;

    state_e         r_state;
    state_e         w_state_nxt;
    logic [HCW-1:0] r_hold_cnt;
    logic [HCW-1:0] w_hold_cnt_nxt;
    logic [HCW-1:0] w_hold_inc;
    logic [GCW-1:0] r_gap_cnt;
    logic [GCW-1:0] w_gap_cnt_nxt;
    logic [GCW-1:0] w_gap_inc;
    logic [ND-1:0]  r_rst_n;
    logic [ND-1:0]  w_rst_n_nxt;
    logic [ND-1:0]  w_rst_n_shift;
    logic           r_busy;
    logic           w_busy_nxt;
    logic [1:0]     r_cause;
    logic [1:0]     w_cause_nxt;
    logic           w_btn_trig;
    logic           w_retrig;

    // Saturating increments so no counter can wrap.
    assign w_deb_inc  = (&r_deb_cnt)  ? r_deb_cnt  : r_deb_cnt  + DCW'(1);
    assign w_hold_inc = (&r_hold_cnt) ? r_hold_cnt : r_hold_cnt + HCW'(1);
    assign w_gap_inc  = (&r_gap_cnt)  ? r_gap_cnt  : r_gap_cnt  + GCW'(1);

    // Released domains form a thermometer code growing from bit 0.
    assign w_rst_n_shift = ND'({r_rst_n, 1'b1});

    assign w_btn_trig = ~r_but_deb;
    assign w_retrig   = w_btn_trig | bus.sw_req;

    // Input synchronisers and button debouncer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_s1 <= 1'b0;
            r_start_s2 <= 1'b0;
            r_but_s1   <= 1'b1;
            r_but_s2   <= 1'b1;
            r_but_deb  <= 1'b1;
            r_deb_cnt  <= '0;
        end else begin
            r_start_s1 <= bus.fpgaStart;
            r_start_s2 <= r_start_s1;
            r_but_s1   <= bus.fpga_but1;
            r_but_s2   <= r_but_s1;
            if (r_but_s2 == r_but_deb) begin
                r_deb_cnt <= '0;
            end else if (w_deb_inc >= DCW'(DEBOUNCE_CYCLES)) begin
                r_but_deb <= r_but_s2;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= w_deb_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_WAIT_START;
            r_hold_cnt <= '0;
            r_gap_cnt  <= '0;
            r_rst_n    <= '0;
            r_busy     <= 1'b1;
            r_cause    <= CAUSE_POWER;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_rst_n    <= w_rst_n_nxt;
            r_busy     <= w_busy_nxt;
            r_cause    <= w_cause_nxt;
        end
    end

    // Loss of fpgaStart outranks every other trigger; button outranks software.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_rst_n_nxt    = r_rst_n;
        w_cause_nxt    = r_cause;

        if (!r_start_s2) begin
            w_state_nxt    = ST_WAIT_START;
            w_hold_cnt_nxt = '0;
            w_gap_cnt_nxt  = '0;
            w_rst_n_nxt    = '0;
            w_cause_nxt    = CAUSE_POWER;
        end else begin
            case (r_state)
                ST_WAIT_START: begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = '0;
                    w_gap_cnt_nxt  = '0;
                    w_rst_n_nxt    = '0;
                end
                ST_HOLD, ST_RELEASE, ST_RUN: begin
                    if (w_retrig) begin
                        w_state_nxt    = ST_HOLD;
                        w_hold_cnt_nxt = '0;
                        w_gap_cnt_nxt  = '0;
                        w_rst_n_nxt    = '0;
                        w_cause_nxt    = w_btn_trig ? CAUSE_BUTTON : CAUSE_SW;
                    end else if (r_state == ST_HOLD) begin
                        w_hold_cnt_nxt = w_hold_inc;
                        if (w_hold_inc >= HCW'(HOLD_CYCLES)) begin
                            w_rst_n_nxt   = ND'(1);
                            w_gap_cnt_nxt = '0;
                            w_state_nxt   = (ND == 1) ? ST_RUN : ST_RELEASE;
                        end
                    end else if (r_state == ST_RELEASE) begin
                        w_gap_cnt_nxt = w_gap_inc;
                        if (w_gap_inc >= GCW'(STAGE_GAP_CYCLES)) begin
                            w_rst_n_nxt   = w_rst_n_shift;
                            w_gap_cnt_nxt = '0;
                            if (&w_rst_n_shift) begin
                                w_state_nxt = ST_RUN;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_WAIT_START;
                end
            endcase
        end

        w_busy_nxt = ~&w_rst_n_nxt;
    end

    assign bus.reset_n = r_rst_n;
    assign bus.busy    = r_busy;
    assign bus.cause   = r_cause;
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: scripted vector table, a release
// latency sequence, then random stimulus against a time-since-trigger model.
module tb_reset_sequencer;
    localparam int HOLD = 20;
    localparam int DEB  = 4;
    localparam int ND   = 3;
    localparam int GAP  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    reset_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

    reset_sequencer #(
        .HOLD_CYCLES      (HOLD),
        .DEBOUNCE_CYCLES  (DEB),
        .NUM_DOMAINS      (ND),
        .STAGE_GAP_CYCLES (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles;
        logic        rst;
        logic        but;
        logic        start;
        logic        sw;
        logic [ND-1:0] exp_rst_n;
        logic        exp_busy;
        logic [1:0]  exp_cause;
    } vec_t;

    vec_t vecs[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    bit chk_model = 1'b0;

    // Reference model state: synchroniser pipes, debounced level, time since t0.
    logic [1:0] m_start_pipe = 2'b00;
    logic [1:0] m_but_pipe   = 2'b11;
    logic       m_deb        = 1'b1;
    logic       m_last_sync  = 1'b1;
    int         m_stable     = 0;
    bit         m_active     = 1'b0;
    int         m_elapsed    = 0;
    logic [1:0] m_cause      = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [ND-1:0] model_rst_n();
        logic [ND-1:0] v;
        v = '0;
        for (int k = 0; k < ND; k++) begin
            v[k] = m_active && (m_elapsed >= HOLD + k * GAP);
        end
        return v;
    endfunction

    task automatic model_step(input logic rst, input logic but, input logic start, input logic sw);
        logic start_sync;
        logic but_sync;
        start_sync = m_start_pipe[1];
        but_sync   = m_but_pipe[1];
        if (rst) begin
            m_start_pipe = 2'b00;
            m_but_pipe   = 2'b11;
            m_deb        = 1'b1;
            m_last_sync  = 1'b1;
            m_stable     = 0;
            m_active     = 1'b0;
            m_elapsed    = 0;
            m_cause      = 2'b00;
        end else begin
            if (!start_sync) begin
                m_active = 1'b0;
                m_cause  = 2'b00;
            end else if (!m_active) begin
                m_active  = 1'b1;
                m_elapsed = 0;
            end else if (!m_deb || sw) begin
                m_elapsed = 0;
                m_cause   = !m_deb ? 2'b01 : 2'b10;
            end else if (m_elapsed < 1000000) begin
                m_elapsed++;
            end
            // Debounced level follows the synced button once it has held DEB samples.
            if (but_sync == m_last_sync) begin
                if (m_stable < 1000) m_stable++;
            end else begin
                m_stable = 1;
            end
            m_last_sync = but_sync;
            if (but_sync != m_deb && m_stable >= DEB) m_deb = but_sync;
            m_start_pipe = {m_start_pipe[0], start};
            m_but_pipe   = {m_but_pipe[0], but};
        end
    endtask

    task automatic step(input logic rst, input logic but, input logic start, input logic sw);
        logic [ND-1:0] exp_rn;
        reset          = rst;
        bus.fpga_but1  = but;
        bus.fpgaStart  = start;
        bus.sw_req     = sw;
        @(posedge clk);
        model_step(rst, but, start, sw);
        #1;
        cyc++;
        if (chk_model) begin
            exp_rn = model_rst_n();
            check("model.reset_n", 32'(bus.reset_n), 32'(exp_rn));
            check("model.busy", 32'(bus.busy), 32'(~&exp_rn));
            check("model.cause", 32'(bus.cause), 32'(m_cause));
        end
    endtask

    task automatic add(input int n, input logic rst, input logic but, input logic start,
                       input logic sw, input logic [ND-1:0] er, input logic eb, input logic [1:0] ec);
        vec_t v;
        v.cycles = n; v.rst = rst; v.but = but; v.start = start; v.sw = sw;
        v.exp_rst_n = er; v.exp_busy = eb; v.exp_cause = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int            lat;
        logic [ND-1:0] th;
        int            but_left;
        logic          but_lvl;
        int            start_left;
        logic          rnd_sw;
        logic          rnd_rst;

        bus.fpga_but1 = 1'b1;
        bus.fpgaStart = 1'b0;
        bus.sw_req    = 1'b0;

        // Power-up: reset, no start, then start -> t0 three cycles later.
        add(2,  1, 1, 0, 0, 3'b000, 1, 2'b00);
        add(3,  0, 1, 0, 0, 3'b000, 1, 2'b00);
        add(22, 0, 1, 1, 0, 3'b000, 1, 2'b00);
        add(1,  0, 1, 1, 0, 3'b001, 1, 2'b00);
        add(4,  0, 1, 1, 0, 3'b001, 1, 2'b00);
        add(1,  0, 1, 1, 0, 3'b011, 1, 2'b00);
        add(4,  0, 1, 1, 0, 3'b011, 1, 2'b00);
        add(1,  0, 1, 1, 0, 3'b111, 0, 2'b00);
        add(5,  0, 1, 1, 0, 3'b111, 0, 2'b00);
        // Two-cycle glitch is rejected.
        add(2,  0, 0, 1, 0, 3'b111, 0, 2'b00);
        add(6,  0, 1, 1, 0, 3'b111, 0, 2'b00);
        // Long press: reset after 7 cycles, release 20 cycles after debounced release.
        add(6,  0, 0, 1, 0, 3'b111, 0, 2'b00);
        add(1,  0, 0, 1, 0, 3'b000, 1, 2'b01);
        add(23, 0, 0, 1, 0, 3'b000, 1, 2'b01);
        add(25, 0, 1, 1, 0, 3'b000, 1, 2'b01);
        add(1,  0, 1, 1, 0, 3'b001, 1, 2'b01);
        add(4,  0, 1, 1, 0, 3'b001, 1, 2'b01);
        add(1,  0, 1, 1, 0, 3'b011, 1, 2'b01);
        add(4,  0, 1, 1, 0, 3'b011, 1, 2'b01);
        add(1,  0, 1, 1, 0, 3'b111, 0, 2'b01);
        // Software request, then a second one at t0+22 restarts the hold.
        add(1,  0, 1, 1, 1, 3'b000, 1, 2'b10);
        add(19, 0, 1, 1, 0, 3'b000, 1, 2'b10);
        add(1,  0, 1, 1, 0, 3'b001, 1, 2'b10);
        add(2,  0, 1, 1, 0, 3'b001, 1, 2'b10);
        add(1,  0, 1, 1, 1, 3'b000, 1, 2'b10);
        add(19, 0, 1, 1, 0, 3'b000, 1, 2'b10);
        add(1,  0, 1, 1, 0, 3'b001, 1, 2'b10);
        add(4,  0, 1, 1, 0, 3'b001, 1, 2'b10);
        add(1,  0, 1, 1, 0, 3'b011, 1, 2'b10);
        add(4,  0, 1, 1, 0, 3'b011, 1, 2'b10);
        add(1,  0, 1, 1, 0, 3'b111, 0, 2'b10);
        // Block reset mid-release: partial release is dropped, restart needs resync.
        add(1,  0, 1, 1, 1, 3'b000, 1, 2'b10);
        add(19, 0, 1, 1, 0, 3'b000, 1, 2'b10);
        add(2,  0, 1, 1, 0, 3'b001, 1, 2'b10);
        add(3,  0, 1, 1, 0, 3'b001, 1, 2'b10);
        add(1,  0, 1, 1, 0, 3'b011, 1, 2'b10);
        add(1,  1, 1, 1, 0, 3'b000, 1, 2'b00);
        add(22, 0, 1, 1, 0, 3'b000, 1, 2'b00);
        add(1,  0, 1, 1, 0, 3'b001, 1, 2'b00);
        add(4,  0, 1, 1, 0, 3'b001, 1, 2'b00);
        add(1,  0, 1, 1, 0, 3'b011, 1, 2'b00);
        add(4,  0, 1, 1, 0, 3'b011, 1, 2'b00);
        add(1,  0, 1, 1, 0, 3'b111, 0, 2'b00);
        // Debounced press and sw_req in the same cycle: button wins, one restart.
        add(6,  0, 0, 1, 0, 3'b111, 0, 2'b00);
        add(1,  0, 0, 1, 1, 3'b000, 1, 2'b01);
        add(25, 0, 1, 1, 0, 3'b000, 1, 2'b01);
        add(1,  0, 1, 1, 0, 3'b001, 1, 2'b01);
        add(4,  0, 1, 1, 0, 3'b001, 1, 2'b01);
        add(1,  0, 1, 1, 0, 3'b011, 1, 2'b01);
        add(4,  0, 1, 1, 0, 3'b011, 1, 2'b01);
        add(1,  0, 1, 1, 0, 3'b111, 0, 2'b01);
        // fpgaStart falls in RUN.
        add(2,  0, 1, 0, 0, 3'b111, 0, 2'b01);
        add(1,  0, 1, 0, 0, 3'b000, 1, 2'b00);
        add(3,  0, 1, 0, 0, 3'b000, 1, 2'b00);
        // Block reset at t0+10.
        add(3,  0, 1, 1, 0, 3'b000, 1, 2'b00);
        add(10, 0, 1, 1, 0, 3'b000, 1, 2'b00);
        add(1,  1, 1, 1, 0, 3'b000, 1, 2'b00);
        add(22, 0, 1, 1, 0, 3'b000, 1, 2'b00);
        add(1,  0, 1, 1, 0, 3'b001, 1, 2'b00);
        add(4,  0, 1, 1, 0, 3'b001, 1, 2'b00);
        add(1,  0, 1, 1, 0, 3'b011, 1, 2'b00);
        add(4,  0, 1, 1, 0, 3'b011, 1, 2'b00);
        add(1,  0, 1, 1, 0, 3'b111, 0, 2'b00);

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step(vecs[i].rst, vecs[i].but, vecs[i].start, vecs[i].sw);
            end
            check($sformatf("vec%0d.reset_n", i), 32'(bus.reset_n), 32'(vecs[i].exp_rst_n));
            check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d.cause", i), 32'(bus.cause), 32'(vecs[i].exp_cause));
        end

        chk_model = 1'b1;

        // Full release after a software trigger takes HOLD + 2*GAP cycles, in order.
        step(0, 1, 1, 1);
        lat = 0;
        while (bus.busy !== 1'b0 && lat < 200) begin
            step(0, 1, 1, 0);
            th = bus.reset_n;
            check("thermometer", 32'(th & (th + ND'(1))), 32'd0);
            lat++;
        end
        check("sw_release_latency", 32'(lat), 32'(HOLD + 2 * GAP));

        but_lvl    = 1'b1;
        but_left   = 0;
        start_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (but_left == 0) begin
                but_lvl  = ~but_lvl;
                but_left = but_lvl ? int'($urandom_range(10, 80)) : int'($urandom_range(1, 12));
            end
            but_left--;
            if (start_left > 0) begin
                start_left--;
            end else if ($urandom_range(0, 499) == 0) begin
                start_left = int'($urandom_range(1, 6));
            end
            rnd_sw  = ($urandom_range(0, 79) == 0);
            rnd_rst = ($urandom_range(0, 999) == 0);
            step(rnd_rst, but_lvl, (start_left == 0), rnd_sw);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter: HOLD_CYCLES, 5000000, clk cycles all domains stay asserted after a trigger (500 ms at 10 MHz).
REQ-002 Parameter: DEBOUNCE_CYCLES, 100000, clk cycles button must be stable before a level change is accepted (10 ms).
REQ-003 Parameter: NUM_DOMAINS, 3, number of reset outputs; legal range 1..8.
REQ-004 Parameter: STAGE_GAP_CYCLES, 16, clk cycles between successive domain releases; legal minimum 1.
REQ-005 Port: clk  input  1  system clock, 10 MHz, sole clock.
REQ-006 Port: reset  input  1  synchronous, active-high block reset.
REQ-007 Port: fpga_but1  input  1  raw push-button, asynchronous, low = pressed.
REQ-008 Port: fpgaStart  input  1  asynchronous, high = FPGA programming finished.
REQ-009 Port: sw_req  input  1  synchronous single-cycle software reset request.
REQ-010 Port: reset_n  output  NUM_DOMAINS  per-domain reset, low active, registered.
REQ-011 Port: busy  output  1  high while any reset_n bit is low.
REQ-012 Port: cause  output  2  last trigger source: 00 power-up/fpgaStart, 01 button, 10 software.

Function
REQ-013 fpga_but1 and fpgaStart SHALL each pass through a 2-flop synchroniser.
REQ-014 Debounce: counter increments while synced button differs from debounced level, clears when equal; when it reaches DEBOUNCE_CYCLES, debounced level takes the synced value and counter clears.
REQ-015 FSM states: WAIT_START, HOLD, RELEASE, RUN.
REQ-016 WAIT_START: all reset_n = 0, busy = 1; transition to HOLD on the edge after synced fpgaStart = 1; hold counter cleared.
REQ-017 HOLD: all reset_n = 0; counter increments each cycle; counter held at 0 while debounced button is low; enter RELEASE when counter reaches HOLD_CYCLES.
REQ-018 Release timing: with t0 = first HOLD cycle counting from 0, reset_n[k] SHALL be 1 from cycle t0 + HOLD_CYCLES + k*STAGE_GAP_CYCLES onward; bits release in ascending index order.
REQ-019 busy SHALL fall in the same cycle the last reset_n bit rises; FSM then enters RUN.
REQ-020 In HOLD, RELEASE or RUN, debounced button low or sw_req = 1 SHALL drive all reset_n to 0 on the next edge and re-enter HOLD with the counter cleared; in HOLD this re-trigger extends the hold.
REQ-021 Synced fpgaStart = 0 in any state SHALL force WAIT_START on the next edge, all reset_n = 0, cause = 00; priority over button and sw_req.
REQ-022 Button and sw_req in the same cycle: cause = 01 (button priority).
REQ-023 cause SHALL update only on the trigger edge and otherwise hold its value.
REQ-024 Counters SHALL be sized $clog2(max parameter + 1) and SHALL saturate, never wrap.
REQ-025 NUM_DOMAINS = 1: the single bit releases at t0 + HOLD_CYCLES; STAGE_GAP_CYCLES is unused.

Reset
REQ-026 reset = 1 SHALL, on the next clk edge and in any state: set state WAIT_START, reset_n all 0, busy 1, cause 00, debounced button 1, button synchroniser 1, fpgaStart synchroniser 0, and all counters 0.
REQ-027 reset asserted mid-HOLD or mid-RELEASE SHALL abort the sequence; no partially released domain remains high.

Verification (HOLD_CYCLES=20, DEBOUNCE_CYCLES=4, NUM_DOMAINS=3, STAGE_GAP_CYCLES=5)
REQ-028 Power-up: fpgaStart rises -> HOLD entered 3 cycles later at t0; reset_n[0], [1], [2] rise at t0+20, t0+25 and t0+30; busy falls at t0+30; cause = 00.
REQ-029 Button low for 2 cycles in RUN -> no output change. Button low for 30 cycles -> all reset_n = 0 within 7 cycles, cause = 01; reset_n[0] rises 20 cycles after the debounced release.
REQ-030 sw_req pulse at t0+22 (reset_n[0] already released) -> all reset_n = 0 next cycle, sequence restarts from HOLD, cause = 10.
REQ-031 Debounced press and sw_req in the same RUN cycle -> cause = 01, single restart.
REQ-032 fpgaStart falls in RUN -> WAIT_START within 3 cycles, all reset_n = 0, cause = 00. reset pulsed at t0+10 -> reset values on the next edge, no release until fpgaStart is re-synced.
